// File: rtl/alu_selftest.sv
// alu_selftest: on-demand self-test sequencer for the 32-bit combinational ALU.
// Walks a fixed 20-entry vector ROM, holds each vector for SETTLE cycles,
// samples the ALU result/zero flag and reports pass, mismatch count and the
// index of the first mismatch.
//
// Parameters:
//   SETTLE       - cycles each vector is held before sampling (1..15)
//   STOP_ON_FAIL - when 1, the run ends at the first mismatching vector
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start               - begin a run (honoured only when idle)
//   alu_a/alu_b/alu_f   - registered ALU operands and function select
//   alu_y/alu_z         - ALU result and zero flag
//   busy                - run in progress (first APPLY through DONE)
//   done                - one-cycle pulse at the end of a run
//   pass                - last completed run had zero mismatches
//   fail_count          - mismatching vectors in the last run
//   first_fail_idx      - index of first mismatch, 5'h1F when none
module alu_selftest #(
  parameter int unsigned SETTLE       = 1,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_f,
  input  logic [31:0] alu_y,
  input  logic        alu_z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [4:0]  first_fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_COMPARE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        z;
  } vec_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);
  localparam logic [4:0] LAST_IDX = 5'd19;
  localparam logic [4:0] NO_FAIL  = 5'h1F;

  function automatic vec_t rom(input logic [4:0] i);
    case (i)
      5'd0:  return '{3'b010, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
      5'd1:  return '{3'b010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      5'd2:  return '{3'b010, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0};
      5'd3:  return '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
      5'd4:  return '{3'b110, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
      5'd5:  return '{3'b110, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      5'd6:  return '{3'b110, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1};
      5'd7:  return '{3'b110, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0};
      5'd8:  return '{3'b111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
      5'd9:  return '{3'b111, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
      5'd10: return '{3'b111, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      5'd11: return '{3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
      5'd12: return '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
      5'd13: return '{3'b000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, 1'b0};
      5'd14: return '{3'b000, 32'h1234_5678, 32'h8765_4321, 32'h0224_4220, 1'b0};
      5'd15: return '{3'b000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      5'd16: return '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
      5'd17: return '{3'b001, 32'h1234_5678, 32'h8765_4321, 32'h9775_5779, 1'b0};
      5'd18: return '{3'b001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
      5'd19: return '{3'b001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
      default: return '0;
    endcase
  endfunction

  state_t     state, state_next;
  logic [4:0] idx, idx_next;
  logic [3:0] cnt, cnt_next;
  vec_t       cur;
  logic       mismatch;

  assign cur = rom(idx);
  // Case equality so an unknown ALU result is flagged rather than silently passing.
  assign mismatch = !((alu_y === cur.y) && (alu_z === cur.z));

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_APPLY;
          idx_next   = '0;
          cnt_next   = '0;
        end
      end
      S_APPLY: begin
        if (cnt == LAST_CNT) begin
          state_next = S_COMPARE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      S_COMPARE: begin
        if (idx == LAST_IDX || (STOP_ON_FAIL && mismatch)) begin
          state_next = S_DONE;
        end else begin
          state_next = S_APPLY;
          idx_next   = idx + 5'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail the FSM by
  // one cycle: the vector and busy appear the edge after start is accepted,
  // and done/busy-fall land one edge after the DONE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt            <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_f          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= NO_FAIL;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
      busy  <= (state != S_IDLE);
      done  <= (state == S_DONE);

      if (state == S_APPLY || state == S_COMPARE) begin
        alu_a <= cur.a;
        alu_b <= cur.b;
        alu_f <= cur.f;
      end else begin
        alu_a <= '0;
        alu_b <= '0;
        alu_f <= '0;
      end

      if (state == S_IDLE && start) begin
        fail_count     <= '0;
        first_fail_idx <= NO_FAIL;
        pass           <= 1'b0;
      end

      if (state == S_COMPARE && mismatch) begin
        fail_count <= fail_count + 5'd1;
        if (first_fail_idx == NO_FAIL) first_fail_idx <= idx;
      end

      if (state == S_DONE) pass <= (fail_count == '0);
    end
  end

endmodule

// File: doc/alu_selftest.md
# alu_selftest

Hardware self-test sequencer for the 32-bit combinational ALU (ops AND 000, OR 001, ADD 010, SUB 110, SLT 111; outputs `y` and zero flag `z`). On `start` it drives a fixed 20-entry vector set onto the ALU inputs one vector at a time. After a settle interval it samples `y`/`z` and compares them against stored expected values. It reports pass/fail, a mismatch count and the first failing index. It sits beside the ALU in the datapath and provides power-on or on-demand checking without a simulator.

## Interface
- `SETTLE`, default 1: cycles each vector is held before sampling; legal values are 1..15.
- `STOP_ON_FAIL`, default 0: when 1, the run terminates at the first mismatch.

- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a run; only honoured in IDLE.
- `alu_a` output 32: ALU operand a, registered.
- `alu_b` output 32: ALU operand b, registered.
- `alu_f` output 3: ALU function select, registered.
- `alu_y` input 32: ALU result.
- `alu_z` input 1: ALU zero flag.
- `busy` output 1: high from the first APPLY cycle through the DONE cycle.
- `done` output 1: one-cycle pulse at the end of a run.
- `pass` output 1: 1 if the last completed run had zero mismatches; held until the next `start`.
- `fail_count` output 5: number of mismatching vectors in the last run.
- `first_fail_idx` output 5: index of the first mismatch; 5'h1F if none.

## Operation
- The vector ROM is listed below as index: f, a, b → expected y, expected z.
  - 0–3 (ADD 010):
    - 0: 0 + 0 → 0, z=1
    - 1: 1 + FFFFFFFF → 0, z=1
    - 2: FF + 1 → 100, z=0
    - 3: FFFFFFFF + 1 → 0, z=1
  - 4–7 (SUB 110):
    - 4: 0 − 0 → 0, z=1
    - 5: 0 − FFFFFFFF → 1, z=0
    - 6: 1 − 1 → 0, z=1
    - 7: 100 − 1 → FF, z=0
  - 8–11 (SLT 111):
    - 8: (0, 0) → 0, z=1
    - 9: (0, 1) → 1, z=0
    - 10: (0, FFFFFFFF) → 0, z=1
    - 11: (FFFFFFFF, 0) → 1, z=0
  - 12–15 (AND 000):
    - 12: FFFFFFFF & FFFFFFFF → FFFFFFFF, z=0
    - 13: FFFFFFFF & 12345678 → 12345678, z=0
    - 14: 12345678 & 87654321 → 02244220, z=0
    - 15: 0 & FFFFFFFF → 0, z=1
  - 16–19 (OR 001):
    - 16: FFFFFFFF | FFFFFFFF → FFFFFFFF, z=0
    - 17: 12345678 | 87654321 → 97755779, z=0
    - 18: 0 | FFFFFFFF → FFFFFFFF, z=0
    - 19: 0 | 0 → 0, z=1
- State machine states are IDLE, APPLY, COMPARE and DONE.
- IDLE:
  - `start`=1 → APPLY with idx=0.
  - On entering APPLY: clear `fail_count`, set `first_fail_idx`=1F, clear `pass`.
- APPLY:
  - Drives ROM[idx] on `alu_a`/`alu_b`/`alu_f`.
  - A settle counter counts SETTLE cycles, then the FSM moves to COMPARE.
- COMPARE:
  - Vector still driven.
  - A mismatch is `alu_y`≠exp_y OR `alu_z`≠exp_z.
  - On a mismatch: `fail_count`+1; if `first_fail_idx`==1F, load idx.
  - Next state is DONE if idx==19, or if (STOP_ON_FAIL and a mismatch occurred this cycle). Otherwise idx+1 → APPLY.
- DONE:
  - `done`=1 for one cycle.
  - `pass`=(`fail_count` after the final compare == 0).
  - Next state is IDLE.
- In IDLE, `alu_a`/`alu_b`/`alu_f` are driven to 0/0/000.
- `start` outside IDLE is ignored; no queuing.
- `start` held high continuously begins a new run each time IDLE is reached.
- The mismatch comparison is full 32-bit equality plus the z bit. No X-tolerance: an X on `alu_y` counts as a mismatch in simulation.

## Timing
- Reset values (the next edge with `reset`=1):
  - state IDLE, idx 0
  - `alu_a`/`alu_b`/`alu_f`=0
  - `busy`=0, `done`=0, `pass`=0
  - `fail_count`=0, `first_fail_idx`=1F
- Reset mid-run aborts immediately to these values; no `done` pulse.
- A run is launched by `start` sampled high in IDLE at edge k. At edge k+1:
  - vector 0 appears on `alu_*`;
  - `busy`=1.
- Each vector occupies SETTLE+1 cycles: SETTLE in APPLY, then 1 in COMPARE.
- A full run without early stop has `done` high in cycle k+1+20·(SETTLE+1). With SETTLE=1 that is k+41.
- `busy` falls in the cycle after `done`.
- `pass`/`fail_count`/`first_fail_idx` are stable from the `done` cycle until the APPLY entry of the next run.
- With STOP_ON_FAIL=1 and the first mismatch at index i, `done` is high in cycle k+1+(i+1)·(SETTLE+1).

## Test plan
- Correct behavioural ALU, SETTLE=1, pulse `start` → `done` at cycle k+41, `pass`=1, `fail_count`=0, `first_fail_idx`=1F. Bench also checks `alu_*` against the ROM in every COMPARE cycle.
- ALU with `z` stuck at 0 → `pass`=0, `fail_count`=9 (indices 0,1,3,4,6,8,10,15,19), `first_fail_idx`=0.
- ALU whose SLT returns 0 for every input, STOP_ON_FAIL=1, SETTLE=1 → `done` at k+1+10·2=k+21, `fail_count`=1, `first_fail_idx`=9.
- ALU with OR bit 31 forced to 0, SETTLE=3 → `done` at k+81, `fail_count`=3 (indices 16,17,18), `first_fail_idx`=16.
- Assert `reset` during APPLY of idx 5, then release → all outputs at reset values, no `done` pulse. A subsequent `start` runs the full sequence from idx 0 and passes.
- Pulse `start` again while `busy`=1 → ignored; exactly one `done` pulse per run. `start` held high → back-to-back runs, each with `done` and `pass`=1.
